// File: rtl/debounced_edge_detector_pkg.sv
// Shared logic-level constants for the input
// conditioning blocks.
package debounced_edge_detector_pkg;

    localparam logic HIGH = 1'b1;
    localparam logic LOW  = 1'b0;

endpackage

// File: rtl/debounced_edge_detector_debounce_filter.sv
// Two-flop synchroniser plus a consecutive-sample
// debounce counter producing a clean registered level.
module debounce_filter
    import debounced_edge_detector_pkg::*;
#(
    parameter int unsigned CYCLES     = 255,
    parameter logic        IDLE_LEVEL = HIGH
) (
    input  logic clk,
    input  logic reset_low,
    input  logic bit_in,
    output logic bit_out
);

    localparam int CW =
        ($clog2(CYCLES) < 1) ? 1 : $clog2(CYCLES);
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic          sync1 = IDLE_LEVEL;
    logic          sync2 = IDLE_LEVEL;
    logic          level = IDLE_LEVEL;
    logic [CW-1:0] count = '0;

    // Any agreeing sample restarts the count, so only
    // an unbroken run of CYCLES samples flips the level.
    always_ff @(posedge clk) begin
        if (!reset_low) begin
            sync1 <= IDLE_LEVEL;
            sync2 <= IDLE_LEVEL;
            level <= IDLE_LEVEL;
            count <= '0;
        end else begin
            sync1 <= bit_in;
            sync2 <= sync1;
            if (sync2 == level) begin
                count <= '0;
            end else if (count == LAST) begin
                level <= sync2;
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    assign bit_out = level;

endmodule

// File: rtl/debounced_edge_detector.sv
// Debounced level plus single-cycle rise/fall strobes
// for one asynchronous, bouncy input line.
module debounced_edge_detector
    import debounced_edge_detector_pkg::*;
#(
    parameter int unsigned CYCLES     = 255,
    parameter logic        IDLE_LEVEL = HIGH
) (
    input  logic clk,
    input  logic reset_low,
    input  logic bit_in,
    output logic bit_out,
    output logic pos_edge,
    output logic neg_edge
);

    logic level;
    logic prev = IDLE_LEVEL;

    debounce_filter #(
        .CYCLES     (CYCLES),
        .IDLE_LEVEL (IDLE_LEVEL)
    ) u_filter (
        .clk       (clk),
        .reset_low (reset_low),
        .bit_in    (bit_in),
        .bit_out   (level)
    );

    always_ff @(posedge clk) begin
        if (!reset_low) begin
            prev <= IDLE_LEVEL;
        end else begin
            prev <= level;
        end
    end

    assign bit_out  = level;
    assign pos_edge = reset_low & level & ~prev;
    assign neg_edge = reset_low & ~level & prev;

endmodule

// File: tb/tb_debounced_edge_detector.sv
// Directed table plus corner sequences and a random
// scoreboard run for debounced_edge_detector.
module tb_debounced_edge_detector;

    typedef struct packed {
        logic rl;
        logic bi;
        logic out;
        logic pos;
        logic neg;
    } vec_t;

    logic clk = 1'b0;
    logic reset_low = 1'b0;
    logic bi4 = 1'b1;
    logic bi255 = 1'b1;
    logic out4, pos4, neg4;
    logic out255, pos255, neg255;

    int total = 0;
    int passed = 0;

    vec_t tbl[$];

    logic m_s1 = 1'b1;
    logic m_s2 = 1'b1;
    logic m_out = 1'b1;
    logic m_prev = 1'b1;
    int   m_run = 0;

    always #5 clk = ~clk;

    debounced_edge_detector #(
        .CYCLES     (4),
        .IDLE_LEVEL (1'b1)
    ) u4 (
        .clk       (clk),
        .reset_low (reset_low),
        .bit_in    (bi4),
        .bit_out   (out4),
        .pos_edge  (pos4),
        .neg_edge  (neg4)
    );

    debounced_edge_detector #(
        .CYCLES     (255),
        .IDLE_LEVEL (1'b1)
    ) u255 (
        .clk       (clk),
        .reset_low (reset_low),
        .bit_in    (bi255),
        .bit_out   (out255),
        .pos_edge  (pos255),
        .neg_edge  (neg255)
    );

    function automatic void add(
        input logic rl, input logic bi,
        input logic out, input logic pos,
        input logic neg, input int n
    );
        for (int i = 0; i < n; i++)
            tbl.push_back('{rl, bi, out, pos, neg});
    endfunction

    task automatic check(
        input string name,
        input logic [2:0] act,
        input logic [2:0] exp
    );
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b expected %b",
                      name, act, exp);
    endtask

    // Reference: run length of samples differing from
    // the output; CYCLES such samples in a row flip it.
    task automatic model(input logic rl, input logic b);
        if (!rl) begin
            m_s1 = 1'b1; m_s2 = 1'b1;
            m_out = 1'b1; m_prev = 1'b1;
            m_run = 0;
        end else begin
            m_prev = m_out;
            if (m_s2 != m_out) begin
                m_run++;
                if (m_run == 4) begin
                    m_out = m_s2;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = b;
        end
    endtask

    task automatic step(
        input logic rl, input logic b4, input logic b255
    );
        reset_low = rl;
        bi4 = b4;
        bi255 = b255;
        @(posedge clk);
        #1;
        model(rl, b4);
    endtask

    initial begin
        logic lvl;
        int len;

        // power-up reset and clean fall
        add(0, 1, 1, 0, 0, 2);
        add(1, 1, 1, 0, 0, 2);
        add(1, 0, 1, 0, 0, 5);
        add(1, 0, 0, 0, 1, 1);
        add(1, 0, 0, 0, 0, 2);
        // clean rise
        add(1, 1, 0, 0, 0, 5);
        add(1, 1, 1, 1, 0, 1);
        add(1, 1, 1, 0, 0, 2);
        // bounce 0,1,0,0,1,0 then steady 0
        add(1, 0, 1, 0, 0, 1);
        add(1, 1, 1, 0, 0, 1);
        add(1, 0, 1, 0, 0, 2);
        add(1, 1, 1, 0, 0, 1);
        add(1, 0, 1, 0, 0, 5);
        add(1, 0, 0, 0, 1, 1);
        add(1, 0, 0, 0, 0, 2);
        add(1, 1, 0, 0, 0, 5);
        add(1, 1, 1, 1, 0, 1);
        add(1, 1, 1, 0, 0, 2);
        // reset pulse at count 2
        add(1, 0, 1, 0, 0, 4);
        add(0, 0, 1, 0, 0, 1);
        add(1, 0, 1, 0, 0, 5);
        add(1, 0, 0, 0, 1, 1);
        add(1, 0, 0, 0, 0, 1);

        foreach (tbl[i]) begin
            step(tbl[i].rl, tbl[i].bi, 1'b1);
            check($sformatf("vec%0d", i),
                  {out4, pos4, neg4},
                  {tbl[i].out, tbl[i].pos, tbl[i].neg});
        end
        check("u255_idle", {out255, pos255, neg255},
              3'b100);

        // glitches of 3 samples never pass
        step(0, 1, 1);
        step(1, 1, 1);
        step(1, 1, 1);
        for (int g = 0; g < 10; g++) begin
            for (int j = 0; j < 6; j++) begin
                step(1, (j < 3) ? 1'b0 : 1'b1, 1'b1);
                check($sformatf("glitch%0d_%0d", g, j),
                      {out4, pos4, neg4}, 3'b100);
            end
        end

        // long filter: falls on edge 257, not 256
        step(0, 1, 1);
        for (int e = 1; e <= 258; e++) begin
            step(1, 1, 0);
            if (e == 256)
                check("c255_e256",
                      {out255, pos255, neg255}, 3'b100);
            if (e == 257)
                check("c255_e257",
                      {out255, pos255, neg255}, 3'b001);
            if (e == 258)
                check("c255_e258",
                      {out255, pos255, neg255}, 3'b000);
        end

        // reset masks a live strobe
        step(0, 1, 1);
        step(1, 1, 1);
        for (int e = 1; e <= 5; e++) begin
            step(1, 0, 1);
            check($sformatf("rstmask_e%0d", e),
                  {out4, pos4, neg4}, 3'b100);
        end
        step(1, 0, 1);
        check("rstmask_fall", {out4, pos4, neg4}, 3'b001);
        reset_low = 1'b0;
        #1;
        check("rstmask_low", {out4, pos4, neg4}, 3'b000);
        step(0, 0, 1);
        check("rstmask_edge", {out4, pos4, neg4}, 3'b100);
        for (int e = 0; e < 3; e++) begin
            step(1, 1, 1);
            check($sformatf("rstmask_idle%0d", e),
                  {out4, pos4, neg4}, 3'b100);
        end

        // random run lengths against the model
        step(0, 1, 1);
        step(1, 1, 1);
        lvl = 1'b1;
        for (int r = 0; r < 60; r++) begin
            lvl = ~lvl;
            len = $urandom_range(1, 8);
            for (int j = 0; j < len; j++) begin
                step(1, lvl, 1'b1);
                check($sformatf("rand%0d_%0d", r, j),
                      {out4, pos4, neg4},
                      {m_out, m_out & ~m_prev,
                       ~m_out & m_prev});
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/debounced_edge_detector.md
Name: debounced_edge_detector

Overview:
- Conditions one asynchronous, bouncy input line, such as a PS/2 clock or data line. It produces a clean, stable level and single-cycle rising and falling edge strobes in the clk domain.
- The line is synchronised, then debounced by requiring CYCLES consecutive cycles of disagreement before the output level changes.
- Edges are detected on the debounced level.
- Sits between the FPGA pins and protocol state machines such as the PS/2 controller.

Parameters:
- CYCLES, 255: number of consecutive synchronised samples differing from the current output required to accept a new level. Legal range 2..65535.
- IDLE_LEVEL, 1'b1: value of the synchronisers, bit_out and the edge history after reset. PS/2 lines idle high.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset_low  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- bit_in  input  1  raw asynchronous line.
- bit_out  output  1  debounced, registered level.
- pos_edge  output  1  one-cycle strobe: bit_out went 0->1.
- neg_edge  output  1  one-cycle strobe: bit_out went 1->0.

Behaviour:
- One clock domain; reset is synchronous and active-low (clk, reset_low).
- Synchroniser:
  - Two flip-flops, sync1 <= bit_in and sync2 <= sync1.
  - sync2 is the only value used downstream.
- Debounce counter:
  - Width is clog2(CYCLES), minimum 1 bit.
  - If sync2 == bit_out: count <= 0.
  - If sync2 != bit_out and count != CYCLES-1: count <= count+1.
  - If sync2 != bit_out and count == CYCLES-1: bit_out <= sync2 and count <= 0.
- Debounce timing:
  - Any single sample where sync2 equals bit_out clears the counter. Glitches shorter than CYCLES cycles never reach bit_out.
  - The counter never wraps; it saturates by acceptance at CYCLES-1.
  - Latency from a clean bit_in transition to the bit_out change is CYCLES+2 clk edges: 2 for synchronisation, CYCLES for the debounce count.
- Edge detector:
  - Register prev <= bit_out every cycle.
  - pos_edge = bit_out & ~prev; neg_edge = ~bit_out & prev. Both are combinational from registers.
  - Each strobe is high for exactly one cycle, in the first cycle in which bit_out holds its new value.
  - pos_edge and neg_edge are never high together.
  - Minimum spacing between strobes is CYCLES cycles.
- Reset (reset_low low at a clock edge):
  - sync1, sync2, bit_out and prev are set to IDLE_LEVEL; count is set to 0.
  - pos_edge and neg_edge are forced 0 while reset_low is low.
  - Reset mid-count discards the partial count.
  - After release, a bit_in held at ~IDLE_LEVEL produces a normal edge after CYCLES+2 cycles.
- Power-up: the same values are loaded by initial assignment, for FPGA targets.
- No combinational path from bit_in to any output.

Decomposition:
- No shared-package content beyond the codebase's existing logic-level constants (HIGH/LOW).
- One sub-module, debounce_filter, contains the synchroniser, counter and bit_out register, with parameter CYCLES and ports clk, reset_low, bit_in, bit_out.
- The edge-history register and strobe logic stay in the top module.

Test Plan:
- CYCLES=4, bit_in held 1 from reset, then driven 0 and held -> bit_out falls exactly 6 edges later. neg_edge is high for exactly 1 cycle, that same cycle; pos_edge stays 0.
- CYCLES=4, bit_in pulsed 0 for 3 cycles then back to 1 (glitch), repeated 10 times -> bit_out stays 1 and no strobes.
- CYCLES=4, bit_in bouncing 0,1,0,0,1,0 then steady 0 -> bit_out falls 6 cycles after the final 1->0 transition, with one neg_edge strobe. Then steady 1 -> one pos_edge strobe 6 cycles later.
- CYCLES=255, bit_in steady 0 -> bit_out falls at cycle 257 after the change, not at 256.
- CYCLES=4, reset_low pulsed low for 1 cycle at count 2 while bit_in=0 -> bit_out stays 1. neg_edge appears 6 cycles after reset release and never during reset.
- Random bit_in with random run lengths 1..2*CYCLES -> scoreboard model matches bit_out exactly. Strobes are one-hot, one per bit_out change and only on changes.
